inst_encoder: RTL and testbench

INST_ENCODER -- requirements
Module: inst_encoder

---
 rtl/inst_encoder_pkg.sv | 41 ++++
 rtl/inst_encoder_fmt.sv | 55 +++++
 rtl/inst_encoder.sv | 117 +++++++++++
 tb/tb_inst_encoder.sv | 272 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/inst_encoder_pkg.sv
// Shared definitions for the instruction loader: opcode values used by the processor
// control block, the instruction formats and the loader FSM states.
package inst_encoder_pkg;

  localparam logic [3:0] OP_ADD  = 4'h0;
  localparam logic [3:0] OP_SUB  = 4'h1;
  localparam logic [3:0] OP_AND  = 4'h2;
  localparam logic [3:0] OP_XOR  = 4'h3;
  localparam logic [3:0] OP_COM  = 4'h4;
  localparam logic [3:0] OP_MUL  = 4'h5;
  localparam logic [3:0] OP_ADDI = 4'h6;
  localparam logic [3:0] OP_SLL  = 4'h7;
  localparam logic [3:0] OP_SRL  = 4'h8;
  localparam logic [3:0] OP_LW   = 4'h9;
  localparam logic [3:0] OP_SW   = 4'hA;
  localparam logic [3:0] OP_BEQ  = 4'hB;
  localparam logic [3:0] OP_J    = 4'hC;
  localparam logic [3:0] OP_JAL  = 4'hD;
  localparam logic [3:0] OP_JR   = 4'hE;

  typedef enum logic [2:0] {
    FMT_R,
    FMT_I,
    FMT_B,
    FMT_J,
    FMT_JR,
    FMT_ILL
  } fmt_e;

  typedef enum logic [1:0] {
    ST_LOAD,
    ST_FLUSH,
    ST_DONE
  } state_e;

  // True when the 12-bit immediate is representable as a signed 4-bit field.
  function automatic logic simm4_ok(input logic [11:0] imm);
    return (imm[11:3] == 9'h000) || (imm[11:3] == 9'h1FF);
  endfunction

endpackage

// File: rtl/inst_encoder_fmt.sv
// Combinational format classifier: picks the instruction format for an opcode,
// packs the 16-bit word and flags illegal opcodes or out-of-range immediates.
module inst_fmt
  import inst_encoder_pkg::*;
(
  input  logic [3:0]  op_i,
  input  logic [3:0]  rd_i,
  input  logic [3:0]  rs_i,
  input  logic [3:0]  rt_i,
  input  logic [11:0] imm_i,
  output logic [15:0] word_o,
  output logic        err_o
);

  fmt_e fmt;
  logic range_ok;

  always_comb begin
    fmt      = FMT_ILL;
    range_ok = 1'b1;
    case (op_i)
      OP_ADD, OP_SUB, OP_AND, OP_XOR, OP_COM, OP_MUL: fmt = FMT_R;
      OP_ADDI, OP_LW, OP_SW: begin
        fmt      = FMT_I;
        range_ok = simm4_ok(imm_i);
      end
      OP_SLL, OP_SRL: begin
        fmt      = FMT_I;
        range_ok = (imm_i[11:4] == 8'h00);
      end
      OP_BEQ: begin
        fmt      = FMT_B;
        range_ok = simm4_ok(imm_i);
      end
      OP_J, OP_JAL: fmt = FMT_J;
      OP_JR:        fmt = FMT_JR;
      default:      fmt = FMT_ILL;
    endcase
  end

  // Out-of-range immediates are still written, truncated to the low nibble.
  always_comb begin
    word_o = 16'h0000;
    case (fmt)
      FMT_R:   word_o = {op_i, rd_i, rs_i, rt_i};
      FMT_I:   word_o = {op_i, rd_i, rs_i, imm_i[3:0]};
      FMT_B:   word_o = {op_i, rs_i, rt_i, imm_i[3:0]};
      FMT_J:   word_o = {op_i, imm_i};
      FMT_JR:  word_o = {op_i, 4'h0, rs_i, 4'h0};
      default: word_o = 16'h0000;
    endcase
    err_o = (fmt == FMT_ILL) || !range_ok;
  end

endmodule

// File: rtl/inst_encoder.sv
// Program loader: accepts instruction field bundles, encodes them and writes them
// into instruction memory while holding the processor, then releases it.
module inst_encoder
  import inst_encoder_pkg::*;
#(
  parameter int ADDR_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [3:0]        in_op,
  input  logic [3:0]        in_rd,
  input  logic [3:0]        in_rs,
  input  logic [3:0]        in_rt,
  input  logic [11:0]       in_imm,
  input  logic              in_last,
  input  logic              start,
  output logic              imem_we,
  output logic [ADDR_W-1:0] imem_addr,
  output logic [15:0]       imem_wdata,
  output logic              cpu_hold,
  output logic              done,
  output logic              err,
  output logic              ovf
);

  state_e            state_q, state_d;
  logic [ADDR_W:0]   count_q, count_d;
  logic              we_q, we_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [15:0]       wdata_q, wdata_d;
  logic              err_q, err_d;
  logic              ovf_q, ovf_d;

  logic [15:0] enc_word;
  logic        enc_err;
  logic        xfer;
  logic        full;

  inst_fmt u_fmt (
    .op_i   (in_op),
    .rd_i   (in_rd),
    .rs_i   (in_rs),
    .rt_i   (in_rt),
    .imm_i  (in_imm),
    .word_o (enc_word),
    .err_o  (enc_err)
  );

  assign xfer = in_valid && (state_q == ST_LOAD);
  // The extra count bit keeps the count from wrapping after the last address.
  assign full = (count_q == {1'b0, {ADDR_W{1'b1}}});

  always_comb begin
    state_d = state_q;
    count_d = count_q;
    we_d    = 1'b0;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    err_d   = err_q;
    ovf_d   = ovf_q;
    case (state_q)
      ST_LOAD: begin
        if (xfer) begin
          we_d    = 1'b1;
          addr_d  = count_q[ADDR_W-1:0];
          wdata_d = enc_word;
          err_d   = err_q | enc_err;
          count_d = count_q + 1'b1;
          if (in_last || full) state_d = ST_FLUSH;
          if (full && !in_last) ovf_d = 1'b1;
        end
      end
      ST_FLUSH: state_d = ST_DONE;
      ST_DONE: begin
        if (start) begin
          state_d = ST_LOAD;
          count_d = '0;
          err_d   = 1'b0;
          ovf_d   = 1'b0;
        end
      end
      default: state_d = ST_LOAD;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_LOAD;
      count_q <= '0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= 16'h0000;
      err_q   <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      err_q   <= err_d;
      ovf_q   <= ovf_d;
    end
  end

  assign in_ready   = (state_q == ST_LOAD);
  assign cpu_hold   = (state_q != ST_DONE);
  assign done       = (state_q == ST_DONE);
  assign imem_we    = we_q;
  assign imem_addr  = addr_q;
  assign imem_wdata = wdata_q;
  assign err        = err_q;
  assign ovf        = ovf_q;

endmodule

// File: tb/tb_inst_encoder.sv
// Randomized bench for inst_encoder: programs of field bundles are loaded and every
// memory write, handshake and status flag is compared against a program-level model.
module tb_inst_encoder;
  import inst_encoder_pkg::*;

  localparam int AW    = 2;
  localparam int DEPTH = 1 << AW;

  logic          clk = 1'b0;
  logic          rst;
  logic          in_valid;
  logic          in_ready;
  logic [3:0]    in_op, in_rd, in_rs, in_rt;
  logic [11:0]   in_imm;
  logic          in_last;
  logic          start;
  logic          imem_we;
  logic [AW-1:0] imem_addr;
  logic [15:0]   imem_wdata;
  logic          cpu_hold, done, err, ovf;

  int checks = 0;
  int errors = 0;

  logic [3:0]  op_a [8];
  logic [3:0]  rd_a [8];
  logic [3:0]  rs_a [8];
  logic [3:0]  rt_a [8];
  logic [11:0] imm_a [8];
  logic        last_a [8];

  inst_encoder #(.ADDR_W(AW)) dut (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_op      (in_op),
    .in_rd      (in_rd),
    .in_rs      (in_rs),
    .in_rt      (in_rt),
    .in_imm     (in_imm),
    .in_last    (in_last),
    .start      (start),
    .imem_we    (imem_we),
    .imem_addr  (imem_addr),
    .imem_wdata (imem_wdata),
    .cpu_hold   (cpu_hold),
    .done       (done),
    .err        (err),
    .ovf        (ovf)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Reference encoding written from the instruction-set rules using signed arithmetic.
  function automatic void ref_enc(input logic [3:0] op, input logic [3:0] rd,
                                  input logic [3:0] rs, input logic [3:0] rt,
                                  input logic [11:0] imm,
                                  output logic [15:0] w, output logic e);
    int simm;
    int uimm;
    simm = $signed(imm);
    uimm = int'(imm);
    e = 1'b0;
    w = 16'h0000;
    case (op)
      OP_ADD, OP_SUB, OP_AND, OP_XOR, OP_COM, OP_MUL: w = {op, rd, rs, rt};
      OP_ADDI, OP_LW, OP_SW: begin
        w = {op, rd, rs, imm[3:0]};
        e = (simm < -8) || (simm > 7);
      end
      OP_SLL, OP_SRL: begin
        w = {op, rd, rs, imm[3:0]};
        e = (uimm > 15);
      end
      OP_BEQ: begin
        w = {op, rs, rt, imm[3:0]};
        e = (simm < -8) || (simm > 7);
      end
      OP_J, OP_JAL: w = {op, imm};
      OP_JR:        w = {op, 4'h0, rs, 4'h0};
      default: begin
        w = 16'h0000;
        e = 1'b1;
      end
    endcase
  endfunction

  task automatic set_b(input int i, input logic [3:0] op, input logic [3:0] rd,
                       input logic [3:0] rs, input logic [3:0] rt,
                       input logic [11:0] imm, input logic last);
    op_a[i] = op; rd_a[i] = rd; rs_a[i] = rs; rt_a[i] = rt; imm_a[i] = imm; last_a[i] = last;
  endtask

  task automatic drive_b(input int i);
    in_op = op_a[i]; in_rd = rd_a[i]; in_rs = rs_a[i]; in_rt = rt_a[i];
    in_imm = imm_a[i]; in_last = last_a[i];
  endtask

  // Loads bundles 0..n-1 from LOAD state and checks everything through to DONE.
  task automatic run_prog(input int n, input int gap_pct);
    int idx = 0;
    int acc = 0;
    int budget = 0;
    bit fin = 0;
    bit exp_err = 0;
    bit exp_ovf = 0;
    logic [15:0] w;
    logic e;
    while (!fin) begin
      @(negedge clk);
      in_valid = (idx < n) && ($urandom_range(0, 99) >= gap_pct);
      if (idx < n) drive_b(idx);
      start = ($urandom_range(0, 3) == 0);
      check("ready_load", 32'(in_ready), 1);
      check("hold_load", 32'(cpu_hold), 1);
      check("done_load", 32'(done), 0);
      @(posedge clk); #1;
      if (in_valid) begin
        ref_enc(op_a[idx], rd_a[idx], rs_a[idx], rt_a[idx], imm_a[idx], w, e);
        check("we", 32'(imem_we), 1);
        check("addr", 32'(imem_addr), acc);
        check("wdata", 32'(imem_wdata), 32'(w));
        $display("write @%0d word %04h (expected %04h)", imem_addr, imem_wdata, w);
        exp_err = exp_err | e;
        if (last_a[idx]) fin = 1;
        else if (acc == DEPTH - 1) begin
          fin = 1;
          exp_ovf = 1;
        end
        acc++;
        idx++;
      end else begin
        check("we_idle", 32'(imem_we), 0);
      end
      check("err_run", 32'(err), 32'(exp_err));
      budget++;
      if (budget > 300) begin
        check("load_timeout", 0, 1);
        fin = 1;
      end
    end
    // FLUSH: the offered bundle stays valid and must not be taken.
    @(negedge clk);
    start = 1'b0;
    in_valid = 1'b1;
    check("ready_flush", 32'(in_ready), 0);
    check("done_flush", 32'(done), 0);
    check("hold_flush", 32'(cpu_hold), 1);
    for (int k = 0; k < 3; k++) begin
      @(posedge clk); #1;
      check("we_done", 32'(imem_we), 0);
      check("done", 32'(done), 1);
      check("hold_done", 32'(cpu_hold), 0);
      check("ready_done", 32'(in_ready), 0);
      check("err_done", 32'(err), 32'(exp_err));
      check("ovf_done", 32'(ovf), 32'(exp_ovf));
    end
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic restart();
    @(negedge clk);
    check("done_before_start", 32'(done), 1);
    start = 1'b1;
    in_valid = 1'b0;
    @(posedge clk); #1;
    start = 1'b0;
    check("ready_restart", 32'(in_ready), 1);
    check("done_restart", 32'(done), 0);
    check("hold_restart", 32'(cpu_hold), 1);
    check("err_restart", 32'(err), 0);
    check("ovf_restart", 32'(ovf), 0);
  endtask

  task automatic check_reset_vals();
    check("rst_we", 32'(imem_we), 0);
    check("rst_addr", 32'(imem_addr), 0);
    check("rst_wdata", 32'(imem_wdata), 0);
    check("rst_hold", 32'(cpu_hold), 1);
    check("rst_done", 32'(done), 0);
    check("rst_err", 32'(err), 0);
    check("rst_ovf", 32'(ovf), 0);
    check("rst_ready", 32'(in_ready), 1);
  endtask

  initial begin
    rst = 1'b1; in_valid = 1'b0; start = 1'b0;
    in_op = '0; in_rd = '0; in_rs = '0; in_rt = '0; in_imm = '0; in_last = 1'b0;
    // Reset wins over a concurrent transfer.
    set_b(0, OP_ADD, 4'h1, 4'h2, 4'h3, 12'h000, 1'b0);
    @(negedge clk);
    in_valid = 1'b1;
    drive_b(0);
    @(posedge clk); #1;
    check_reset_vals();
    @(negedge clk);
    rst = 1'b0;
    in_valid = 1'b0;
    @(posedge clk); #1;
    check("we_after_rst", 32'(imem_we), 0);

    set_b(0, OP_ADD, 4'h3, 4'h1, 4'h2, 12'h000, 1'b0);
    set_b(1, OP_SW, 4'h4, 4'h5, 4'h0, 12'hFFE, 1'b1);
    run_prog(2, 0);
    restart();

    set_b(0, OP_ADDI, 4'h1, 4'h2, 4'h0, 12'h010, 1'b0);
    set_b(1, OP_ADD, 4'h1, 4'h1, 4'h1, 12'h000, 1'b1);
    run_prog(2, 0);
    restart();

    set_b(0, OP_JAL, 4'h0, 4'h0, 4'h0, 12'hABC, 1'b1);
    run_prog(1, 0);
    restart();

    for (int i = 0; i < 5; i++) set_b(i, OP_XOR, 4'(i), 4'h7, 4'h8, 12'h000, 1'b0);
    run_prog(5, 0);
    restart();

    set_b(0, OP_BEQ, 4'h0, 4'h2, 4'h3, 12'h001, 1'b1);
    run_prog(1, 0);
    restart();

    // Reset while a write is pending cancels it and clears sticky flags.
    @(negedge clk);
    in_valid = 1'b1;
    in_op = 4'hF; in_last = 1'b0;
    @(posedge clk); #1;
    check("pend_we", 32'(imem_we), 1);
    check("pend_err", 32'(err), 1);
    @(negedge clk);
    rst = 1'b1;
    in_valid = 1'b0;
    @(posedge clk); #1;
    check_reset_vals();
    @(negedge clk);
    rst = 1'b0;

    for (int p = 0; p < 25; p++) begin
      int n;
      bit with_last;
      with_last = ($urandom_range(0, 2) != 0);
      n = with_last ? int'($urandom_range(1, 6)) : int'($urandom_range(4, 6));
      for (int i = 0; i < n; i++) begin
        logic [11:0] imm;
        case ($urandom_range(0, 2))
          0: imm = 12'($signed($urandom_range(0, 15)) - 8);
          1: imm = 12'($urandom_range(0, 15));
          default: imm = 12'($urandom);
        endcase
        set_b(i, 4'($urandom), 4'($urandom), 4'($urandom), 4'($urandom), imm,
              with_last && (i == n - 1));
      end
      run_prog(n, 30);
      restart();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
